frame_mode_controller: RTL

Sequences the camera-to-LCD output arbitrator.
- Debounces the raw mode switches and applies a new display mode only in vertical blanking (iFval low), so a frame is never split between modes.
- Drives the matching enables to the RGB/gray/histogram/threshold/cumulative-histogram stages.
- Owns the threshold level (key up/down) and a frame counter.

---
 rtl/frame_mode_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/frame_mode_controller.sv
// frame_mode_controller
//   Sequences the camera-to-LCD output arbitrator. Raw mode switches are
//   debounced, and a new mode or threshold level is applied only in vertical
//   blanking, so that no frame is ever split between two modes. The block also
//   drives the stage enables, holds the threshold level and counts frames.
//
// Ports
//   iClk             system clock, rising edge
//   iRst_n           synchronous active-low reset
//   iFval            frame valid from capture (high during active frame)
//   iSelect[2:0]     raw mode switches
//   iKeyUp/iKeyDown  threshold keys, level, active-high, already debounced
//   oSelect[2:0]     applied mode to the arbitrator
//   oMode_Valid      oSelect is a legal mode (1..5)
//   oStage_En[4:0]   stage enables {cumhist, thresh, hist, gray, rgb}
//   oThresholdLevel  applied threshold level
//   oFrame_Count     completed frames since reset (wraps)
//   oSwitch_Pending  debounced mode or shadow threshold differs from applied
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_SYNC  | after reset; wait for blanking so a partial frame is ignored
// ST_IDLE  | vertical blanking; pending mode/threshold is applied here
// ST_FRAME | active frame; outputs frozen until iFval falls
module frame_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int THRESH_STEP     = 8,
  parameter int THRESH_DEFAULT  = 128
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iFval,
  input  logic [2:0]  iSelect,
  input  logic        iKeyUp,
  input  logic        iKeyDown,
  output logic [2:0]  oSelect,
  output logic        oMode_Valid,
  output logic [4:0]  oStage_En,
  output logic [7:0]  oThresholdLevel,
  output logic [15:0] oFrame_Count,
  output logic        oSwitch_Pending
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    THR_DEF  = 8'(THRESH_DEFAULT);
  localparam logic [7:0]    THR_STEP = 8'(THRESH_STEP);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    s_q;
  logic [CW-1:0] db_cnt;
  logic [2:0]    sel_db;
  logic [7:0]    thr_shadow;
  logic          fval_d;
  logic          key_up_d;
  logic          key_down_d;

  logic          pending;
  logic          do_apply;
  logic          frame_end;
  logic          sel_match;
  logic          up_rise;
  logic          down_rise;
  logic [8:0]    thr_up_sum;
  logic [7:0]    thr_up;
  logic [7:0]    thr_down;

  function automatic logic [4:0] stage_decode(input logic [2:0] mode);
    logic [4:0] en;
    case (mode)
      3'd1:    en = 5'b00001;
      3'd2:    en = 5'b00011;
      3'd3:    en = 5'b00111;
      3'd4:    en = 5'b01011;
      3'd5:    en = 5'b10111;
      default: en = 5'b00000;
    endcase
    return en;
  endfunction

  assign pending    = (sel_db != oSelect) || (thr_shadow != oThresholdLevel);
  assign sel_match  = (iSelect == s_q);
  assign up_rise    = iKeyUp & ~key_up_d;
  assign down_rise  = iKeyDown & ~key_down_d;
  assign thr_up_sum = {1'b0, thr_shadow} + {1'b0, THR_STEP};
  assign thr_up     = thr_up_sum[8] ? 8'hFF : thr_up_sum[7:0];
  assign thr_down   = (thr_shadow < THR_STEP) ? 8'h00 : (thr_shadow - THR_STEP);

  always_comb begin
    state_nxt = state;
    do_apply  = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_SYNC: begin
        if (!iFval) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // A frame starting on this edge wins over a pending apply.
        if (iFval) state_nxt = ST_FRAME;
        else if (pending) do_apply = 1'b1;
      end
      ST_FRAME: begin
        if (!iFval && fval_d) begin
          frame_end = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state           <= ST_SYNC;
      s_q             <= 3'd0;
      db_cnt          <= '0;
      sel_db          <= 3'd0;
      thr_shadow      <= THR_DEF;
      fval_d          <= 1'b0;
      key_up_d        <= 1'b0;
      key_down_d      <= 1'b0;
      oSelect         <= 3'd0;
      oMode_Valid     <= 1'b0;
      oStage_En       <= 5'b00000;
      oThresholdLevel <= THR_DEF;
      oFrame_Count    <= 16'd0;
      oSwitch_Pending <= 1'b0;
    end else begin
      state      <= state_nxt;
      fval_d     <= iFval;
      key_up_d   <= iKeyUp;
      key_down_d <= iKeyDown;

      // Debounce: db_cnt counts consecutive edges with iSelect == s_q; the
      // DEBOUNCE_CYCLES-th match (count already at max-1) loads sel_db.
      s_q <= iSelect;
      if (!sel_match) begin
        db_cnt <= '0;
      end else begin
        if (db_cnt != CNT_MAX) db_cnt <= db_cnt + CW'(1);
        if (db_cnt == CNT_MAX) sel_db <= s_q;
      end

      if (up_rise && !down_rise) thr_shadow <= thr_up;
      else if (down_rise && !up_rise) thr_shadow <= thr_down;

      if (do_apply) begin
        oSelect         <= sel_db;
        oThresholdLevel <= thr_shadow;
        oStage_En       <= stage_decode(sel_db);
        oMode_Valid     <= (sel_db >= 3'd1) && (sel_db <= 3'd5);
      end

      if (frame_end) oFrame_Count <= oFrame_Count + 16'd1;

      oSwitch_Pending <= pending;
    end
  end

endmodule
